// File: rtl/qdec_qp_derive.sv
// -----------------------------------------------------------------------------
// qdec_qp_derive
//
// Luma QP derivation for one CU at a time. The delta-QP decoder upstream
// delivers cu_qp_delta_abs/sign; this block forms the QP predictor from the
// left/above quantization-group neighbours inside the current CTB, or from
// qPY_PREV at the CTB/QG edges. It then adds the delta and wraps the result
// into the legal range. The final QpY' (QpY + QpBdOffset) goes to dequant.
//
// A per-CTB QP map at 8x8 granularity (8x8 entries) holds the QP of every
// decoded CU so that later quantization groups can predict from it.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   slice_start, slice_qp        new-slice pulse and SliceQpY + QpBdOffset
//   cu_start + geometry          CU position/size and QG flags (IDLE only)
//   log2_qg_size                 Log2MinCuQpDeltaSize
//   dqp_vld, cu_qp_delta_*       decoded delta QP (accepted in any state)
//   cu_done                      start derivation (IDLE only)
//   busy                         derivation/map update in progress
//   qp_y, qp_y_vld               derived QpY' and its one-cycle strobe
//
// Handshake: cu_start/cu_done are single-cycle pulses. They are accepted only
// while busy is low. Pulses that arrive while busy is high are dropped.
// qp_y is valid in the cycle qp_y_vld is high and holds until the next CU.
// -----------------------------------------------------------------------------
module qdec_qp_derive #(
    parameter int QP_BD_OFFSET = 0,
    parameter int QP_W         = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            slice_start,
    input  logic [QP_W-1:0] slice_qp,
    input  logic            cu_start,
    input  logic [2:0]      cu_x8,
    input  logic [2:0]      cu_y8,
    input  logic [2:0]      cu_log2_size,
    input  logic            qg_first,
    input  logic            qg_first_in_row,
    input  logic [2:0]      log2_qg_size,
    input  logic            dqp_vld,
    input  logic [7:0]      cu_qp_delta_abs,
    input  logic            cu_qp_delta_sign,
    input  logic            cu_done,
    output logic            busy,
    output logic [QP_W-1:0] qp_y,
    output logic            qp_y_vld
);

    localparam int QP_RANGE = 52 + QP_BD_OFFSET;

    typedef enum logic [1:0] {IDLE, PRED, CALC, WRITE} state_e;

    state_e          state_q,      state_d;
    logic [QP_W-1:0] last_qp_q,    last_qp_d;
    logic [QP_W-1:0] qg_prev_qp_q, qg_prev_qp_d;
    logic [8:0]      delta_q,      delta_d;     // two's complement CuQpDeltaVal
    logic [2:0]      xqg_q,        xqg_d;
    logic [2:0]      yqg_q,        yqg_d;
    logic [2:0]      cu_x8_q,      cu_x8_d;
    logic [2:0]      cu_y8_q,      cu_y8_d;
    logic [2:0]      cu_log2_q,    cu_log2_d;
    logic [QP_W-1:0] pred_q,       pred_d;
    logic [QP_W-1:0] qp_y_q,       qp_y_d;
    logic            qp_y_vld_q,   qp_y_vld_d;
    logic [2:0]      row_cnt_q,    row_cnt_d;
    logic [QP_W-1:0] map_q [8][8];
    logic [QP_W-1:0] map_d [8][8];

    // Combinational helpers
    logic [2:0]      qg_mask;
    logic [8:0]      delta_mag;
    logic [QP_W-1:0] qa, qb;
    logic [QP_W:0]   pred_sum;
    logic [10:0]     s0, s1, s2;
    logic [QP_W-1:0] qp_mod;
    logic [3:0]      n_cells;
    logic [2:0]      row_idx;

    // QG alignment: clear the low (log2_qg_size-3) bits of the 8x8 coordinate.
    assign qg_mask   = 3'b111 << (log2_qg_size - 3'd3);
    assign delta_mag = {1'b0, cu_qp_delta_abs};

    // Neighbours outside the current CTB are replaced by qPY_PREV. Stale map
    // entries from earlier CTBs therefore never reach the predictor.
    assign qa       = (xqg_q == 3'd0) ? qg_prev_qp_q : map_q[yqg_q][xqg_q - 3'd1];
    assign qb       = (yqg_q == 3'd0) ? qg_prev_qp_q : map_q[yqg_q - 3'd1][xqg_q];
    assign pred_sum = {1'b0, qa} + {1'b0, qb} + {{QP_W{1'b0}}, 1'b1};

    // pred already carries one QpBdOffset, so one range is added to keep the
    // sum non-negative for legal deltas. Two conditional subtracts then give
    // the modulo.
    assign s0     = 11'(pred_q) + {{2{delta_q[8]}}, delta_q} + 11'(QP_RANGE);
    assign s1     = (s0 >= 11'(QP_RANGE)) ? s0 - 11'(QP_RANGE) : s0;
    assign s2     = (s1 >= 11'(QP_RANGE)) ? s1 - 11'(QP_RANGE) : s1;
    assign qp_mod = QP_W'(s2);

    assign n_cells = 4'd1 << (cu_log2_q - 3'd3);
    assign row_idx = cu_y8_q + row_cnt_q;

    always_comb begin
        state_d      = state_q;
        last_qp_d    = last_qp_q;
        qg_prev_qp_d = qg_prev_qp_q;
        delta_d      = delta_q;
        xqg_d        = xqg_q;
        yqg_d        = yqg_q;
        cu_x8_d      = cu_x8_q;
        cu_y8_d      = cu_y8_q;
        cu_log2_d    = cu_log2_q;
        pred_d       = pred_q;
        qp_y_d       = qp_y_q;
        qp_y_vld_d   = 1'b0;
        row_cnt_d    = row_cnt_q;
        map_d        = map_q;

        if (cu_start && state_q == IDLE) begin
            cu_x8_d   = cu_x8;
            cu_y8_d   = cu_y8;
            cu_log2_d = cu_log2_size;
            if (qg_first) begin
                delta_d      = 9'd0;
                xqg_d        = cu_x8 & qg_mask;
                yqg_d        = cu_y8 & qg_mask;
                qg_prev_qp_d = (qg_first_in_row || slice_start) ? slice_qp : last_qp_q;
            end
        end

        // A later delta in the same QG overwrites the earlier one.
        if (dqp_vld) begin
            delta_d = cu_qp_delta_sign ? (~delta_mag + 9'd1) : delta_mag;
        end

        case (state_q)
            IDLE: begin
                if (cu_done) state_d = PRED;
            end
            PRED: begin
                pred_d  = QP_W'(pred_sum >> 1);
                state_d = CALC;
            end
            CALC: begin
                qp_y_d     = qp_mod;
                last_qp_d  = qp_mod;
                qp_y_vld_d = 1'b1;
                row_cnt_d  = 3'd0;
                state_d    = WRITE;
            end
            WRITE: begin
                // One map row per cycle. Indices wrap inside the 8x8 grid.
                for (int c = 0; c < 8; c++) begin
                    if (c < int'(n_cells)) map_d[row_idx][cu_x8_q + 3'(c)] = qp_y_q;
                end
                row_cnt_d = row_cnt_q + 3'd1;
                if ({1'b0, row_cnt_q} == n_cells - 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (slice_start) last_qp_d = slice_qp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_qp_q    <= '0;
            qg_prev_qp_q <= '0;
            delta_q      <= '0;
            xqg_q        <= '0;
            yqg_q        <= '0;
            cu_x8_q      <= '0;
            cu_y8_q      <= '0;
            cu_log2_q    <= 3'd3;
            pred_q       <= '0;
            qp_y_q       <= '0;
            qp_y_vld_q   <= 1'b0;
            row_cnt_q    <= '0;
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) map_q[r][c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            last_qp_q    <= last_qp_d;
            qg_prev_qp_q <= qg_prev_qp_d;
            delta_q      <= delta_d;
            xqg_q        <= xqg_d;
            yqg_q        <= yqg_d;
            cu_x8_q      <= cu_x8_d;
            cu_y8_q      <= cu_y8_d;
            cu_log2_q    <= cu_log2_d;
            pred_q       <= pred_d;
            qp_y_q       <= qp_y_d;
            qp_y_vld_q   <= qp_y_vld_d;
            row_cnt_q    <= row_cnt_d;
            map_q        <= map_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign qp_y     = qp_y_q;
    assign qp_y_vld = qp_y_vld_q;

endmodule
